mult_sched: RTL

//  Shares one bit_serial_mult among NREQ requesters (e.g. the x*x, y*y and x*y

---
 rtl/mult_sched_if.sv | 28 ++
 rtl/mult_sched.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mult_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_sched_if : requester-side bus of the shared multiplier sched.  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mult_sched_if #(
  parameter int NREQ = 3,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [2*W-1:0]    res_data;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, res_valid, res_id, res_data
  );
endinterface
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_sched : round-robin scheduler sharing one bit-serial multiplier |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mult_sched #(
  parameter int NREQ    = 3,
  parameter int W       = 8,
  parameter int TIMEOUT = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mult_sched_if.slave         bus,
  output logic                err,
  output logic                mult_rst_n,
  output logic                mult_start,
  output logic [W-1:0]        mult_x,
  output logic [W-1:0]        mult_y,
  input  wire logic [2*W-1:0] mult_out,
  input  wire logic           mult_finished
);

  localparam int IW = 2;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gid;
  logic [IW-1:0]     grant_id;
  logic              grant_any;
  logic [NREQ-1:0]   grant_oh;
  logic [CW-1:0]     wd_cnt;
  logic              wd_fire;
  logic              transfer;

  function automatic logic [IW-1:0] wrap(input int v);
    return (v >= NREQ) ? IW'(v - NREQ) : IW'(v);
  endfunction

  // Walk the offsets from the far end back to rr_ptr so the last hit wins,
  // i.e. the first valid requester at or after rr_ptr.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap(int'(rr_ptr) + k)]) begin
        grant_id  = wrap(int'(rr_ptr) + k);
        grant_any = 1'b1;
      end
    end
  end

  assign grant_oh      = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign bus.req_ready = (state_q == IDLE) ? grant_oh : '0;
  assign transfer      = (state_q == IDLE) && grant_any;

  assign wd_fire    = (state_q == BUSY) && !mult_finished &&
                      (wd_cnt == CW'(TIMEOUT - 1));
  assign mult_start = (state_q == LAUNCH);

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_id    = (state_q == DONE) ? gid : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = LAUNCH;
      LAUNCH:  state_d = BUSY;
      BUSY:    if (mult_finished || wd_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      gid          <= '0;
      mult_x       <= '0;
      mult_y       <= '0;
      bus.res_data <= '0;
      err          <= 1'b0;
      wd_cnt       <= '0;
      mult_rst_n   <= 1'b0;
    end else begin
      // One-cycle low pulse kicks a hung multiplier back to its idle state.
      mult_rst_n <= ~wd_fire;

      if (transfer) begin
        mult_x <= bus.req_x[int'(grant_id) * W +: W];
        mult_y <= bus.req_y[int'(grant_id) * W +: W];
        gid    <= grant_id;
        rr_ptr <= wrap(int'(grant_id) + 1);
      end

      if (state_q == LAUNCH) begin
        wd_cnt <= '0;
      end else if (state_q == BUSY) begin
        if (mult_finished) begin
          bus.res_data <= mult_out;
        end else if (wd_fire) begin
          err          <= 1'b1;
          bus.res_data <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
